riscv: RTL and testbench
========================

RISCV -- requirements
Module: riscv

Interface
REQ-001 Parameters SHALL be none; memory sizes and widths are fixed.
REQ-002 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port enable_load_ex_mem SHALL be an input, 1 bit: external memory-load mode.
REQ-006 Port InstExMemAddress SHALL be an input, 9 bits: instruction-memory load byte address.
REQ-007 Ports InstExMemData1 and InstExMemData2 SHALL be inputs, 32 bits each: instruction words loaded at InstExMemAddress and InstExMemAddress+4.
REQ-008 Port DataExMemAddress SHALL be an input, 9 bits: data-memory load byte address.
REQ-009 Ports DataExMemData1 and DataExMemData2 SHALL be inputs, 32 bits each: data words loaded at DataExMemAddress and DataExMemAddress+4.
REQ-010 Port WB_Data SHALL be an output, 32 bits: write-back value of the current instruction.
REQ-011 Port reg_num SHALL be an output, 5 bits: rd field of the current instruction.
REQ-012 Port reg_data SHALL be an output, 32 bits: present contents of x[reg_num], read before the write.
REQ-013 Port reg_write_sig SHALL be an output, 1 bit: register write enable.
REQ-014 Ports wr and rd SHALL be outputs, 1 bit each: data-memory write and read strobes.
REQ-015 Port addr SHALL be an output, 9 bits: data-memory byte address (ALU result[8:0]).
REQ-016 Ports wr_data and rd_data SHALL be outputs, 32 bits each: store data, and the raw memory word read.

Function
REQ-017 Instruction and data memories SHALL each be 128 x 32-bit words, byte-addressed through addr[8:2], little-endian.
REQ-018 While enable_load_ex_mem=1, each rising edge SHALL write Data1 to word[A>>2] and Data2 to word[(A+4)>>2] in both memories; the PC is held and no register or memory writes from execution occur.
REQ-019 External loading SHALL work whether or not reset is asserted.
REQ-020 The core SHALL be single-cycle: one instruction retires per rising edge when enable_load_ex_mem=0 and reset=1.
REQ-021 The core SHALL decode ADD, SUB, AND, OR, XOR, SLT, ADDI, ANDI, ORI, LB, LH, LW, LBU, LHU, BEQ and BNE; stores are decoded per REQ-035.
REQ-022 Any other encoding, including 0x00000000, SHALL act as a NOP: PC+4 and no writes.
REQ-023 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; the byte and halfword lane is selected by addr[1:0].
REQ-024 Misaligned LH and LW SHALL use the aligned word, with no trap.
REQ-025 Branch targets SHALL be PC+sign-extended B-immediate; the PC is 9 bits and wraps modulo 512.
REQ-026 x0 SHALL read as zero, and writes to x0 are discarded while reg_write_sig still reflects the decode.
REQ-027 rd SHALL be 1 only for loads, and wr only for stores; both are 0 otherwise.
REQ-028 wr_data SHALL equal rs2 for stores and 0 otherwise.
REQ-029 All status outputs SHALL be combinational from the current instruction.

Reset
REQ-030 reset=0 SHALL asynchronously set the PC to 0 and clear x1..x31.
REQ-031 While reset=0, execution SHALL be halted.
REQ-032 Memories SHALL NOT be cleared by reset.
REQ-033 After reset, WB_Data, reg_num, reg_write_sig, wr, rd, addr, wr_data and rd_data SHALL reflect decode of the word at address 0, or all 0 if that word is 0.
REQ-034 Deasserting reset mid-load SHALL NOT corrupt loaded words.

Configuration
REQ-035 With macro RISCV_STORE_EN defined, SB, SH and SW SHALL write the selected byte, halfword or word with wr=1; without it, store opcodes SHALL be NOPs with wr=0.

Verification
REQ-036 Load instruction words 0x00100393, 0x00400113, 0x00000233, 0x00038303 and data word0=0xFFFFAA80, then run 4 cycles -> x7=1, x2=4, x4=0, x6=0xFFFFFFAA (LB byte1).
REQ-037 Continue with 0x00020333, 0x00030383, 0x00031403, 0x00032483 -> x6=0, x7=0xFFFFFF80, x8=0xFFFFAA80, x9=0xFFFFAA80, with rd=1 on each load.
REQ-038 Execute LBU from address 1 with word0=0xFFFFAA80 -> 0x000000AA; LHU from address 0 -> 0x0000AA80.
REQ-039 Run BEQ x0,x0,-8 from PC=8 -> PC=0; BNE with equal operands -> PC+4.
REQ-040 Assert reset=0 mid-program -> PC=0 and registers=0 immediately, while memory words are retained.
REQ-041 With RISCV_STORE_EN, execute SW x2,4(x0) -> wr=1, addr=4, wr_data=4, and a subsequent LW of word1 returns 4; without the macro, wr stays 0 and word1 is unchanged.

Source files
------------

// File: rtl/riscv.sv
// Single-cycle RV32I subset core with 128x32 instruction/data memories and an external load port.
// One instruction retires per clock; optional stores are enabled by defining RISCV_STORE_EN.
module riscv (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_load_ex_mem,
  input  logic [8:0]  InstExMemAddress,
  input  logic [31:0] InstExMemData1,
  input  logic [31:0] InstExMemData2,
  input  logic [8:0]  DataExMemAddress,
  input  logic [31:0] DataExMemData1,
  input  logic [31:0] DataExMemData2,
  output logic [31:0] WB_Data,
  output logic [4:0]  reg_num,
  output logic [31:0] reg_data,
  output logic        reg_write_sig,
  output logic        wr,
  output logic        rd,
  output logic [8:0]  addr,
  output logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  logic [31:0] imem_q [128];
  logic [31:0] dmem_q [128];
  logic [31:0] rf_q   [32];
  logic [31:0] rf_d   [32];
  logic [8:0]  pc_q, pc_d;

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd_f;
  logic [31:0] rs1_v, rs2_v, imm_i, alu_res, mem_word, ld_val, wb_val, st_word;
  logic [8:0]  br_off, inst_addr_hi, data_addr_hi;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        is_alu, is_load, is_store, br_taken, run, st_we;
  logic        unused_addr_bits;

  assign inst   = imem_q[pc_q[8:2]];
  assign opcode = inst[6:0];
  assign rd_f   = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign rs1_v  = rf_q[rs1];
  assign rs2_v  = rf_q[rs2];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  // The PC is only 9 bits wide, so only the low bits of the B-immediate matter.
  assign br_off = {inst[28:25], inst[11:8], 1'b0};
  assign run    = reset & ~enable_load_ex_mem;

  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    br_taken = 1'b0;
    alu_res  = '0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          is_alu = 1'b1;
          case (funct3)
            3'b000:  alu_res = rs1_v + rs2_v;
            3'b010:  alu_res = {31'd0, $signed(rs1_v) < $signed(rs2_v)};
            3'b100:  alu_res = rs1_v ^ rs2_v;
            3'b110:  alu_res = rs1_v | rs2_v;
            3'b111:  alu_res = rs1_v & rs2_v;
            default: is_alu = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          is_alu  = 1'b1;
          alu_res = rs1_v - rs2_v;
        end
      end
      7'b0010011: begin
        is_alu = 1'b1;
        case (funct3)
          3'b000:  alu_res = rs1_v + imm_i;
          3'b110:  alu_res = rs1_v | imm_i;
          3'b111:  alu_res = rs1_v & imm_i;
          default: is_alu = 1'b0;
        endcase
      end
      7'b0000011: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            is_load = 1'b1;
            alu_res = rs1_v + imm_i;
          end
          default: ;
        endcase
      end
      7'b1100011: begin
        case (funct3)
          3'b000:  br_taken = (rs1_v == rs2_v);
          3'b001:  br_taken = (rs1_v != rs2_v);
          default: ;
        endcase
      end
`ifdef RISCV_STORE_EN
      7'b0100011: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: begin
            is_store = 1'b1;
            alu_res  = rs1_v + {{20{inst[31]}}, inst[31:25], inst[11:7]};
          end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
  end

  assign mem_word = dmem_q[alu_res[8:2]];

  always_comb begin
    byte_v = mem_word[{alu_res[1:0], 3'b000} +: 8];
    half_v = alu_res[1] ? mem_word[31:16] : mem_word[15:0];
    case (funct3)
      3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b100:  ld_val = {24'd0, byte_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = mem_word;
    endcase
  end

`ifdef RISCV_STORE_EN
  always_comb begin
    st_word = mem_word;
    case (funct3)
      3'b000:  st_word[{alu_res[1:0], 3'b000} +: 8] = rs2_v[7:0];
      3'b001:  st_word[{alu_res[1], 4'b0000} +: 16] = rs2_v[15:0];
      default: st_word = rs2_v;
    endcase
  end
  assign st_we = run & is_store;
`else
  assign st_word = '0;
  assign st_we   = 1'b0;
`endif

  assign wb_val        = is_load ? ld_val : (is_alu ? alu_res : 32'd0);
  assign WB_Data       = wb_val;
  assign reg_num       = rd_f;
  assign reg_data      = rf_q[rd_f];
  assign reg_write_sig = is_alu | is_load;
  assign rd            = is_load;
  assign wr            = is_store;
  assign addr          = alu_res[8:0];
  assign wr_data       = is_store ? rs2_v : 32'd0;
  assign rd_data       = is_load ? mem_word : 32'd0;

  always_comb begin
    pc_d = pc_q;
    rf_d = rf_q;
    if (run) begin
      pc_d = br_taken ? pc_q + br_off : pc_q + 9'd4;
      if (reg_write_sig && rd_f != 5'd0) rf_d[rd_f] = wb_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

  assign inst_addr_hi = InstExMemAddress + 9'd4;
  assign data_addr_hi = DataExMemAddress + 9'd4;
  assign unused_addr_bits = ^{InstExMemAddress[1:0], DataExMemAddress[1:0],
                              inst_addr_hi[1:0], data_addr_hi[1:0]};

  // Memories sit outside the reset domain so contents survive any reset activity.
  always_ff @(posedge clk) begin
    if (enable_load_ex_mem) begin
      imem_q[InstExMemAddress[8:2]] <= InstExMemData1;
      imem_q[inst_addr_hi[8:2]]     <= InstExMemData2;
      dmem_q[DataExMemAddress[8:2]] <= DataExMemData1;
      dmem_q[data_addr_hi[8:2]]     <= DataExMemData2;
    end else if (st_we) begin
      dmem_q[alu_res[8:2]] <= st_word;
    end
  end

endmodule

// File: tb/tb_riscv.sv
// Randomized bench for riscv: a behavioural ISA model tracks memories, registers and PC,
// and every cycle the DUT's combinational outputs are compared against it.
module tb_riscv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [8:0]  ia = '0, da = '0;
  logic [31:0] id1 = '0, id2 = '0, dd1 = '0, dd2 = '0;
  logic [31:0] WB_Data, reg_data, wr_data, rd_data;
  logic [4:0]  reg_num;
  logic        reg_write_sig, wr, rd;
  logic [8:0]  addr;

  always #5 clk = ~clk;

  riscv dut (
    .clk(clk), .reset(reset), .enable_load_ex_mem(en),
    .InstExMemAddress(ia), .InstExMemData1(id1), .InstExMemData2(id2),
    .DataExMemAddress(da), .DataExMemData1(dd1), .DataExMemData2(dd2),
    .WB_Data(WB_Data), .reg_num(reg_num), .reg_data(reg_data),
    .reg_write_sig(reg_write_sig), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data)
  );

  typedef struct packed {
    logic [31:0] wb;
    logic [4:0]  rnum;
    logic [31:0] rdata;
    logic        rw, w, r;
    logic [8:0]  a;
    logic [31:0] wd, rdd;
    logic [8:0]  npc;
    logic [31:0] sw;
    logic        chka, chkwb, chkrd;
  } exp_t;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;
  logic [31:0] mi [128];
  logic [31:0] md [128];
  logic [31:0] mx [32];
  logic [8:0]  mpc = '0;
  logic [31:0] prog [128];
  logic [31:0] dat [128];
  exp_t ce, se;
  wire [8:0] ia4 = ia + 9'd4;
  wire [8:0] da4 = da + 9'd4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (pc=%0d t=%0t)", nm, act, exp, mpc, $time);
    end
  endtask

  // Architectural meaning of the instruction at the model PC, from model state.
  function automatic exp_t predict();
    exp_t e;
    logic [31:0] ins, a, b, ea, w, imm;
    logic [12:0] bimm;
    logic [7:0]  bt;
    logic [15:0] hw;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    e = '0;
    ins = mi[mpc[8:2]];
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = mx[ins[19:15]]; b = mx[ins[24:20]];
    e.rnum = ins[11:7];
    e.rdata = mx[ins[11:7]];
    e.npc = mpc + 9'd4;
    if (ins == 32'd0) begin
      e.chka = 1'b1; e.chkwb = 1'b1; e.chkrd = 1'b1;
    end else if (op == 7'h33 && ((f7 == 7'h00 && f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) ||
                                 (f7 == 7'h20 && f3 == 3'd0))) begin
      e.rw = 1'b1;
      if (f7 == 7'h20) e.wb = a - b;
      else if (f3 == 3'd0) e.wb = a + b;
      else if (f3 == 3'd2) e.wb = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else if (f3 == 3'd4) e.wb = a ^ b;
      else if (f3 == 3'd6) e.wb = a | b;
      else e.wb = a & b;
    end else if (op == 7'h13 && f3 inside {3'd0, 3'd6, 3'd7}) begin
      imm = 32'($signed(ins[31:20]));
      e.rw = 1'b1;
      e.wb = (f3 == 3'd0) ? a + imm : (f3 == 3'd6) ? (a | imm) : (a & imm);
    end else if (op == 7'h03 && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
      ea = a + 32'($signed(ins[31:20]));
      w = md[ea[8:2]];
      bt = 8'(w >> (int'(ea[1:0]) * 8));
      hw = 16'(w >> (ea[1] ? 16 : 0));
      e.rw = 1'b1; e.r = 1'b1; e.rdd = w;
      if (f3 == 3'd0) e.wb = 32'($signed(bt));
      else if (f3 == 3'd1) e.wb = 32'($signed(hw));
      else if (f3 == 3'd2) e.wb = w;
      else if (f3 == 3'd4) e.wb = 32'(bt);
      else e.wb = 32'(hw);
      e.a = ea[8:0];
    end else if (op == 7'h63 && f3 inside {3'd0, 3'd1}) begin
      bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      if ((a == b) == (f3 == 3'd0)) e.npc = 9'(32'(mpc) + 32'($signed(bimm)));
`ifdef RISCV_STORE_EN
    end else if (op == 7'h23 && f3 inside {3'd0, 3'd1, 3'd2}) begin
      ea = a + 32'($signed({ins[31:25], ins[11:7]}));
      w = md[ea[8:2]];
      if (f3 == 3'd0) w[int'(ea[1:0]) * 8 +: 8] = b[7:0];
      else if (f3 == 3'd1) w[(ea[1] ? 16 : 0) +: 16] = b[15:0];
      else w = b;
      e.w = 1'b1; e.wd = b; e.sw = w; e.a = ea[8:0]; e.chka = 1'b1;
`endif
    end
    if (e.rw) begin
      e.chkwb = 1'b1;
      e.chka = 1'b1;
      if (!e.r) e.a = e.wb[8:0];
    end
    if (e.r) e.chkrd = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    se = predict();
    if (en) begin
      mi[ia[8:2]] <= id1; mi[ia4[8:2]] <= id2;
      md[da[8:2]] <= dd1; md[da4[8:2]] <= dd2;
    end else if (reset) begin
      if (se.rw && se.rnum != 5'd0) mx[se.rnum] <= se.wb;
      if (se.w) md[se.a[8:2]] <= se.sw;
      mpc <= se.npc;
    end
  end

  always @(negedge reset) begin
    mpc <= '0;
    for (int i = 0; i < 32; i++) mx[i] <= '0;
  end

  always @(negedge clk) begin
    if (check_en) begin
      ce = predict();
      if (ce.chkwb) chk("WB_Data", WB_Data, ce.wb);
      chk("reg_num", 32'(reg_num), 32'(ce.rnum));
      chk("reg_data", reg_data, ce.rdata);
      chk("reg_write_sig", 32'(reg_write_sig), 32'(ce.rw));
      chk("wr", 32'(wr), 32'(ce.w));
      chk("rd", 32'(rd), 32'(ce.r));
      if (ce.chka) chk("addr", 32'(addr), 32'(ce.a));
      chk("wr_data", wr_data, ce.wd);
      if (ce.chkrd) chk("rd_data", rd_data, ce.rdd);
    end
  end

  function automatic logic [31:0] gen_inst();
    logic [31:0] r, ins;
    logic [4:0]  rd_, rs1_, rs2_;
    logic [2:0]  f3;
    logic [12:0] bi;
    logic [6:0]  jop;
    r = $urandom;
    rd_ = 5'($urandom_range(0, 7));
    rs1_ = 5'($urandom_range(0, 7));
    rs2_ = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: ins = {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, rs2_, rs1_, f3, rd_, 7'h33};
      1: ins = {r[31:20], rs1_, f3, rd_, 7'h13};
      2, 3: ins = {r[31:20], rs1_, f3, rd_, 7'h03};
      4: begin
        bi = 13'($urandom_range(0, 31) * 4 - 64);
        ins = {bi[12], bi[10:5], rs2_, rs1_, 3'($urandom_range(0, 2)), bi[4:1], bi[11], 7'h63};
      end
      5: ins = {r[31:25], rs2_, rs1_, 3'($urandom_range(0, 3)), r[11:7], 7'h23};
      6: begin
        case ($urandom_range(0, 4))
          0: jop = 7'h6f;
          1: jop = 7'h37;
          2: jop = 7'h17;
          3: jop = 7'h73;
          default: jop = 7'h7f;
        endcase
        ins = {r[31:7], jop};
      end
      default: ins = 32'd0;
    endcase
    return ins;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int r;
    #1 reset = 1'b0;
    for (int i = 0; i < 128; i++) begin
      prog[i] = gen_inst();
      dat[i] = $urandom;
    end
    prog[0] = 32'h00100393; prog[1] = 32'h00400113; prog[2] = 32'h00000233;
    prog[3] = 32'h00038303; prog[4] = 32'h00020333; prog[5] = 32'h00030383;
    prog[6] = 32'h00031403; prog[7] = 32'h00032483; prog[8] = 32'h00104503;
    prog[9] = 32'h00005583; prog[10] = 32'h00202223; prog[11] = 32'h00402603;
    prog[12] = 32'h00001463; prog[13] = 32'h05500693; prog[14] = 32'h06600693;
    dat[0] = 32'hFFFFAA80; dat[1] = 32'h12345678;

    // Fill both memories while held in reset.
    en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ia = 9'(i * 8); id1 = prog[2 * i]; id2 = prog[2 * i + 1];
      da = 9'(i * 8); dd1 = dat[2 * i]; dd2 = dat[2 * i + 1];
      tick();
    end
    en = 1'b0;
    check_en = 1'b1;
    chk("rst_wb", WB_Data, 32'd1);
    chk("rst_reg_num", 32'(reg_num), 32'd7);
    chk("rst_reg_data", reg_data, 32'd0);
    reset = 1'b1;
    tick(); chk("addi_x2", WB_Data, 32'd4);
    tick(); chk("add_x4_we", 32'(reg_write_sig), 32'd1); chk("add_x4", WB_Data, 32'd0);
    tick(); chk("lb_byte1", WB_Data, 32'hFFFFFFAA); chk("lb_rd", 32'(rd), 32'd1); chk("lb_addr", 32'(addr), 32'd1);
    tick(); chk("old_x6", reg_data, 32'hFFFFFFAA); chk("add_x6", WB_Data, 32'd0);
    tick(); chk("lb_byte0", WB_Data, 32'hFFFFFF80); chk("old_x7", reg_data, 32'd1); chk("lb0_rd", 32'(rd), 32'd1);
    tick(); chk("lh", WB_Data, 32'hFFFFAA80); chk("lh_rd", 32'(rd), 32'd1);
    tick(); chk("lw", WB_Data, 32'hFFFFAA80); chk("lw_rd_data", rd_data, 32'hFFFFAA80); chk("lw_rd", 32'(rd), 32'd1);
    tick(); chk("lbu", WB_Data, 32'h000000AA);
    tick(); chk("lhu", WB_Data, 32'h0000AA80);
    tick();
`ifdef RISCV_STORE_EN
    chk("sw_wr", 32'(wr), 32'd1); chk("sw_addr", 32'(addr), 32'd4); chk("sw_data", wr_data, 32'd4);
    tick(); chk("lw_after_sw", WB_Data, 32'd4);
`else
    chk("sw_wr", 32'(wr), 32'd0); chk("sw_data", wr_data, 32'd0);
    tick(); chk("lw_after_sw", WB_Data, 32'h12345678);
`endif
    tick(); chk("bne_we", 32'(reg_write_sig), 32'd0);
    tick(); chk("bne_fallthru", WB_Data, 32'h55);
    chk("model_x2", mx[2], 32'd4); chk("model_x4", mx[4], 32'd0); chk("model_x6", mx[6], 32'd0);
    chk("model_x7", mx[7], 32'hFFFFFF80); chk("model_x8", mx[8], 32'hFFFFAA80);
    chk("model_x9", mx[9], 32'hFFFFAA80); chk("model_x10", mx[10], 32'hAA);

    // Mid-program reset clears state at once; reload part of imem across the reset release.
    reset = 1'b0;
    #1;
    chk("async_rst_reg", reg_data, 32'd0);
    chk("async_rst_pc", WB_Data, 32'd1);
    en = 1'b1; ia = 9'd8; id1 = 32'hFE000CE3; id2 = prog[3]; da = 9'd8; dd1 = md[2]; dd2 = md[3];
    tick();
    reset = 1'b1; ia = 9'd16; id1 = prog[4]; id2 = prog[5]; da = 9'd16; dd1 = md[4]; dd2 = md[5];
    tick();
    en = 1'b0;
    chk("reload_pc0", WB_Data, 32'd1);
    tick(); tick(); chk("beq_we", 32'(reg_write_sig), 32'd0);
    tick(); chk("beq_target_wb", WB_Data, 32'd1); chk("beq_target_x7", reg_data, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      en = 1'b0; reset = 1'b1;
      if (r < 5) begin
        en = 1'b1;
        ia = 9'($urandom); id1 = gen_inst(); id2 = gen_inst();
        da = 9'($urandom); dd1 = $urandom; dd2 = $urandom;
        reset = ($urandom_range(0, 1) == 1);
      end else if (r < 8) begin
        reset = 1'b0;
      end
      tick();
    end
    en = 1'b0; reset = 1'b1;
    tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
